// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, req/ack fetch from instruction memory, one-entry
// skid buffer for decode back-pressure, and an IF/ID register feeding decode.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic [5:0]  opcode
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        valid_n;
  logic [31:0] instr_n, pc4_n;
  logic [31:0] skid_instr, skid_instr_n;
  logic [31:0] skid_pc4, skid_pc4_n;
  logic        kill, kill_n;
  logic [31:0] pend_pc, pend_pc_n;

  logic        if_free;
  logic        got_ack;
  logic [31:0] pc_plus4;
  logic [31:0] target;

  // Handshake: imem_req stays high with imem_addr frozen at pc from the first
  // cycle of a fetch until the cycle imem_ack is seen; ack with req low is ignored.
  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign opcode    = if_instr[31:26];

  assign if_free  = !if_valid || !stall;
  assign got_ack  = imem_ack && (state == FETCH);
  assign pc_plus4 = pc + 32'd4;
  assign target   = {redirect_pc[31:2], 2'b00};

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    valid_n      = if_valid;
    instr_n      = if_instr;
    pc4_n        = if_pc_plus4;
    skid_instr_n = skid_instr;
    skid_pc4_n   = skid_pc4;
    kill_n       = kill;
    pend_pc_n    = pend_pc;

    // Decode takes the current entry; a load below may refill it.
    if (!stall) valid_n = 1'b0;

    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        if (got_ack) begin
          if (kill) begin
            pc_n   = pend_pc;
            kill_n = 1'b0;
          end else if (if_free) begin
            instr_n = imem_rdata;
            pc4_n   = pc_plus4;
            valid_n = 1'b1;
            pc_n    = pc_plus4;
          end else begin
            skid_instr_n = imem_rdata;
            skid_pc4_n   = pc_plus4;
            pc_n         = pc_plus4;
            state_n      = FULL;
          end
        end
      end
      FULL: begin
        if (!stall) begin
          instr_n = skid_instr;
          pc4_n   = skid_pc4;
          valid_n = 1'b1;
          state_n = FETCH;
        end
      end
      default: state_n = IDLE;
    endcase

    // Redirect wins over everything; an in-flight request must still complete,
    // so its target is parked in pend_pc and the returning word is dropped.
    if (redirect) begin
      valid_n      = 1'b0;
      instr_n      = if_instr;
      pc4_n        = if_pc_plus4;
      skid_instr_n = 32'd0;
      skid_pc4_n   = 32'd0;
      if (state == FETCH && !got_ack) begin
        kill_n    = 1'b1;
        pend_pc_n = target;
        pc_n      = pc;
        state_n   = FETCH;
      end else begin
        pc_n    = target;
        kill_n  = 1'b0;
        state_n = FETCH;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= 32'd0;
      if_pc_plus4 <= 32'd0;
      skid_instr  <= 32'd0;
      skid_pc4    <= 32'd0;
      kill        <= 1'b0;
      pend_pc     <= 32'd0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      if_valid    <= valid_n;
      if_instr    <= instr_n;
      if_pc_plus4 <= pc4_n;
      skid_instr  <= skid_instr_n;
      skid_pc4    <= skid_pc4_n;
      kill        <= kill_n;
      pend_pc     <= pend_pc_n;
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage feeding the main control decoder. Holds the PC, fetches 32-bit instructions from instruction memory over a req/ack handshake, and presents them in an IF/ID register with a valid flag. The `opcode` output drives the control decoder's `Opcode` input directly. Also handles decode back-pressure (`stall`) and branch/jump redirects, including redirects that arrive while a fetch is outstanding.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset. Bits [1:0] must be 0.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  fetch request. Held high until `imem_ack`.
- `imem_addr`  out  32  fetch address. Equals the current PC; stable while `imem_req` is high.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle. Ignored when `imem_req` is low.
- `imem_rdata`  in  32  instruction word.
- `stall`  in  1  decode cannot accept a new IF/ID entry this cycle.
- `redirect`  in  1  branch taken or jump: flush the pipeline and refetch from `redirect_pc`.
- `redirect_pc`  in  32  redirect target. Bits [1:0] are forced to 0 internally.
- `if_valid`  out  1  IF/ID register holds a live instruction.
- `if_instr`  out  32  IF/ID instruction.
- `if_pc_plus4`  out  32  address of `if_instr` + 4.
- `opcode`  out  6  `if_instr[31:26]`, combinational.

## Operation
- FSM states:
  - **IDLE:** entered on reset; moves to FETCH unconditionally on the next edge.
  - **FETCH:** `imem_req` = 1.
  - **FULL:** one fetched word is parked in the skid register; `imem_req` = 0.
- IF/ID "free" means `!if_valid || !stall`.
- FETCH with ack, no kill, no redirect:
  - If IF/ID is free: IF/ID ← {`imem_rdata`, pc+4}, `if_valid` ← 1, pc ← pc+4, stay in FETCH.
  - If IF/ID is not free: skid ← {`imem_rdata`, pc+4}, pc ← pc+4, go to FULL.
- FULL with `!stall`: IF/ID ← skid, go to FETCH.
- When IF/ID is consumed (`!stall`) and nothing new is loaded, `if_valid` ← 0.
- Redirect has the highest priority and takes effect regardless of `stall`:
  - `if_valid` ← 0 and the skid is cleared.
  - If no request is outstanding (IDLE, FULL, or FETCH with ack this cycle): pc ← `redirect_pc`; the acked word is discarded; next state is FETCH.
  - If in FETCH without ack: set `kill` and latch `pend_pc` ← `redirect_pc`. `imem_addr` keeps the old PC until ack.
  - FETCH with ack while `kill` is set: discard the word, pc ← `pend_pc`, clear `kill`, stay in FETCH.
  - A further redirect while `kill` is set overwrites `pend_pc`; the newest target wins.
  - Redirect in the same cycle as an ack with `kill` set: pc ← the new `redirect_pc`.
- Arithmetic: pc+4 is computed modulo 2^32 (32'hFFFF_FFFC + 4 wraps to 0).

## Timing
- Reset values (asynchronous): pc=`RESET_PC`, state=IDLE, `if_valid`=0, `if_instr`=0, `if_pc_plus4`=0, skid=0, `kill`=0, `pend_pc`=0. Outputs during reset: `imem_req`=0, `opcode`=0.
- After reset release:
  - Edge 1: IDLE → FETCH.
  - Cycle 1: `imem_req` is high with `imem_addr` = `RESET_PC`.
  - With a same-cycle ack, `if_valid` = 1 from cycle 2.
- Throughput: one instruction per cycle with zero-wait memory and no stall.
- Fetch latency: one cycle from ack to IF/ID.
- Redirect latency: asserting `redirect` in cycle N with no outstanding request gives `imem_addr` = target in cycle N+1 and `if_valid` = 0 in cycle N+1.
- Handshake rule: `imem_req` never drops and `imem_addr` never changes before ack, including across redirects.
- Reset mid-fetch: the outstanding request is abandoned.

## Test plan
- **Reset and stream.** `RESET_PC`=0, memory always acks, `mem[k]`=k<<26 → `imem_addr` = 0, 4, 8, …; `if_valid` from cycle 2; `opcode` = 0, 1, 2, … one per cycle; `if_pc_plus4` = 4, 8, 12, ….
- **Stall with skid.** Assert `stall` for 3 cycles while streaming → exactly one word parked, `imem_req` low while in FULL; after release, the IF/ID sequence is gapless with no duplicates and no loss.
- **Redirect, no outstanding request.** `redirect`=1, `redirect_pc`=32'h0000_0103 → next `imem_addr` = 32'h0000_0100 and `if_valid`=0 for one cycle.
- **Redirect during a wait-state fetch.** Memory acks 3 cycles late; redirect to 0x200 in cycle 1 → `imem_addr` holds the old PC until ack; the returned word never reaches IF/ID; next request is to 0x200.
- **Double redirect while kill is set.** Redirect to 0x300, then to 0x400 before ack → the fetch after the ack is at 0x400.
- **Wrap and async reset.** pc = 32'hFFFF_FFFC with ack → next `imem_addr` = 0; asserting `rst` mid-cycle immediately clears `if_valid` and `imem_req`.
